// File: rtl/starfield_layers.sv
// Multi-layer scrolling starfield: per-layer LFSR star generator whose
// frame length is stretched or shrunk to scroll, with priority merge.
module starfield_layers #(
  parameter int LAYERS = 3,
  parameter int H_TOT  = 800,
  parameter int V_TOT  = 525,
  parameter logic [LAYERS*21-1:0] SEEDS  = {LAYERS{21'h1FFFFF}},
  parameter logic [LAYERS*21-1:0] MASKS  = {LAYERS{21'h7FF}},
  parameter logic [LAYERS*4-1:0]  SPEEDS = {4'd4, 4'd2, 4'd1}
) (
  input  logic              clk_pix,
  input  logic              rst_pix,
  input  logic              en,
  input  logic              dir,
  input  logic              pause,
  output logic              star_on,
  output logic [3:0]        star_bright,
  output logic [2:0]        star_layer,
  output logic [LAYERS-1:0] layer_wrap
);

  localparam int TOTAL = H_TOT * V_TOT;
  localparam int CW    = $clog2(TOTAL + 16);

  function automatic logic [20:0] seed_of(input int l);
    logic [20:0] s;
    s = SEEDS[21*l +: 21];
    return (s == 21'h0) ? 21'h1 : s;
  endfunction

  logic [LAYERS-1:0]      on;
  logic [LAYERS-1:0]      wrap;
  logic [LAYERS-1:0][3:0] bright;

  for (genvar g = 0; g < LAYERS; g++) begin : g_layer
    localparam logic [CW-1:0] TOT  = CW'(TOTAL);
    localparam logic [CW-1:0] SPD  = CW'(SPEEDS[4*g +: 4]);
    localparam logic [20:0]   SEED = seed_of(g);
    localparam logic [20:0]   MASK = MASKS[21*g +: 21];

    logic [20:0]   lfsr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] last;
    logic          dir_q;
    logic          pause_q;

    // frame length shrinks by SPD to scroll left, grows to scroll right
    always_comb begin
      last = TOT - CW'(1);
      if (!pause_q) begin
        if (dir_q) last = TOT + SPD - CW'(1);
        else       last = TOT - SPD - CW'(1);
      end
    end

    assign on[g]     = &(lfsr | MASK);
    assign bright[g] = lfsr[7:4];
    assign wrap[g]   = en && (cnt == last);

    always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
        cnt     <= '0;
        lfsr    <= SEED;
        dir_q   <= 1'b0;
        pause_q <= 1'b0;
      end else if (en) begin
        if (cnt == last) begin
          cnt     <= '0;
          lfsr    <= SEED;
          dir_q   <= dir;
          pause_q <= pause;
        end else begin
          cnt  <= cnt + CW'(1);
          lfsr <= {lfsr[19:0], lfsr[20] ^ lfsr[18]};
        end
      end
    end
  end

  logic       sel_on;
  logic [3:0] sel_bright;
  logic [2:0] sel_layer;

  // walk downward so the lowest lit layer is the last to win
  always_comb begin
    sel_on     = 1'b0;
    sel_bright = 4'h0;
    sel_layer  = 3'd0;
    for (int l = LAYERS - 1; l >= 0; l--) begin
      if (on[l]) begin
        sel_on     = 1'b1;
        sel_bright = bright[l];
        sel_layer  = 3'(l);
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      star_on     <= 1'b0;
      star_bright <= 4'h0;
      star_layer  <= 3'd0;
      layer_wrap  <= '0;
    end else begin
      star_on     <= sel_on;
      star_bright <= sel_bright;
      star_layer  <= sel_layer;
      layer_wrap  <= wrap;
    end
  end

endmodule

// File: doc/starfield_layers.md
STARFIELD_LAYERS -- requirements
Module: starfield_layers

Interface
REQ-001 Parameter LAYERS, default 3: number of starfield layers; legal range 1..8.
REQ-002 Parameter H_TOT, default 800: total pixel clocks per line, blanking included.
REQ-003 Parameter V_TOT, default 525: total lines per frame, blanking included; TOTAL = H_TOT*V_TOT.
REQ-004 Parameter SEEDS, LAYERS*21 bits, default all 21'h1FFFFF: per-layer LFSR seed, layer l at bits [21l+20:21l]; a zero seed SHALL be replaced by 21'h1 at elaboration.
REQ-005 Parameter MASKS, LAYERS*21 bits, default all 21'h7FF: per-layer density mask.
REQ-006 Parameter SPEEDS, LAYERS*4 bits, default {4'd4,4'd2,4'd1}: per-layer scroll, pixels per frame, layer l at [4l+3:4l]; legal range 1..15.
REQ-007 clk_pix  in  1  pixel clock; one clock only.
REQ-008 rst_pix  in  1  reset; synchronous, active-high.
REQ-009 en  in  1  advance all layers this cycle.
REQ-010 dir  in  1  0 = scroll left, 1 = scroll right.
REQ-011 pause  in  1  1 = stars static.
REQ-012 star_on  out  1  some layer has a star at this pixel.
REQ-013 star_bright  out  4  brightness of the winning layer.
REQ-014 star_layer  out  3  index of the winning layer.
REQ-015 layer_wrap  out  LAYERS  per-layer frame-restart pulse.

Function
REQ-016 Each layer SHALL hold a 21-bit Fibonacci LFSR with next = {lfsr[19:0], lfsr[20]^lfsr[18]}.
REQ-017 Each layer SHALL hold a position counter cnt, width clog2(TOTAL+16), that counts 0..LEN_l-1.
REQ-018 LEN_l SHALL be TOTAL-SPEED_l when the latched mode is left, TOTAL+SPEED_l when it is right, and TOTAL when it is paused; pause overrides dir.
REQ-019 On a cycle with en=1 and cnt!=LEN_l-1, cnt SHALL increment and the LFSR SHALL step.
REQ-020 On a cycle with en=1 and cnt==LEN_l-1, cnt SHALL load 0, the LFSR SHALL load SEED_l, and the layer's latched dir and pause SHALL capture the dir and pause inputs.
REQ-021 dir and pause changes SHALL therefore take effect only at that layer's wrap, with no mid-frame tearing; each layer latches independently.
REQ-022 With en=0, cnt, LFSR and latched mode SHALL hold.
REQ-023 Combinational on_l = &(lfsr_l | MASK_l), and bright_l = lfsr_l[7:4].
REQ-024 Priority SHALL go to the lowest layer index with on_l=1.
REQ-025 Outputs SHALL be registered with 1-cycle latency, updating every cycle regardless of en.
REQ-026 Output registers SHALL be sampled from the pre-step LFSR state.
REQ-027 When no layer is on, outputs SHALL be star_on=0, star_bright=0, star_layer=0.
REQ-028 layer_wrap[l] SHALL be 1 in the cycle after a REQ-020 wrap of layer l, else 0.
REQ-029 Simultaneous wraps on several layers SHALL each assert their own bit.

Reset
REQ-030 With rst_pix=1 at a clock edge, every cnt SHALL be 0 and every LFSR SHALL be SEED_l.
REQ-031 Under the same reset, latched dir and pause SHALL be 0 (scroll left, not paused).
REQ-032 Under the same reset, star_on, star_bright, star_layer and layer_wrap SHALL all be 0.
REQ-033 Reset SHALL take priority over en, including mid-frame.
REQ-034 After reset deasserts, the first cycle with en=1 SHALL produce outputs, one cycle later, that are a function of the SEED_l states.

Verification
REQ-035 LAYERS=1, H_TOT=8, V_TOT=4, SPEEDS=2, dir=0, pause=0, en=1: layer_wrap[0] pulses every 30 cycles, first pulse on the 31st cycle after reset release.
REQ-036 Same config, dir=1 held from reset: the first frame is 30 cycles, since latched dir=0 from reset; thereafter layer_wrap[0] pulses every 34 cycles.
REQ-037 Same config, pause=1: after the first wrap, period is 32 cycles; deasserting pause mid-frame leaves the current frame at 32 cycles.
REQ-038 MASKS=21'h1FFFFF, SEED=21'h000F0: star_on=1 every cycle, and the first output after reset release has star_bright=4'hF.
REQ-039 LAYERS=3, all masks all-ones: star_layer is always 0; with layer 0 mask 0 and SEED0 not all-ones, layer 1 wins.
REQ-040 Assert rst_pix for one cycle at cnt=17 with en=1: next cycle cnt=0, LFSR=SEED, all outputs 0, then the sequence replays as from power-on.
